fetch_ctl: RTL and testbench
============================

FETCH_CTL -- requirements
Module: fetch_ctl

Interface
REQ-001 Parameter: PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT_CYC, 255, FETCH cycles without imem_ack before timeout (used only under FETCH_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_f  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  leave IDLE and begin fetching.
REQ-006 stall  input  1  hold current instruction; blocks PC update.
REQ-007 next_pc  input  32  selected next PC from the downstream 32-bit PC select mux.
REQ-008 pc_out  output  32  current PC.
REQ-009 pc_inc  output  32  pc_out + 1, drives the PC select mux sequential input.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  fetch address, equal to pc_out.
REQ-012 imem_ack  input  1  memory data valid this cycle.
REQ-013 imem_data  input  32  fetched instruction word.
REQ-014 ir_out  output  32  instruction register.
REQ-015 ir_valid  output  1  ir_out holds an unconsumed instruction.
REQ-016 ir_ready  input  1  decode accepts ir_out this cycle.
REQ-017 timeout_err  output  1  sticky fetch timeout flag.

Function
REQ-018 FSM states: IDLE, FETCH, HOLD; the FSM shall be a registered state machine with combinational next-state logic.
REQ-019 IDLE: outputs imem_req=0, ir_valid=0; start=1 -> FETCH next cycle; otherwise IDLE.
REQ-020 FETCH: imem_req=1 continuously until imem_ack; on imem_ack, ir_out<=imem_data and the FSM -> HOLD; imem_req=0 from the following cycle.
REQ-021 FETCH: stall shall not block ack capture; imem_ack and stall in the same cycle still capture and enter HOLD.
REQ-022 HOLD: ir_valid=1; handshake completes when ir_ready=1 and stall=0; then pc_out<=next_pc, ir_valid<=0, and the FSM -> FETCH.
REQ-023 HOLD with ir_ready=0 or stall=1: pc_out, ir_out, and ir_valid held unchanged.
REQ-024 pc_out shall change only on a HOLD handshake completion or on reset.
REQ-025 pc_inc = pc_out + 1, modulo 2^32; 32'hFFFF_FFFF shall wrap to 32'h0000_0000.
REQ-026 Handshake latency: handshake-complete cycle, then imem_req=1 with the new address on the next cycle.
REQ-027 start shall be ignored outside IDLE.

Reset
REQ-028 rst_f=0 shall immediately set: state=IDLE, pc_out=PC_RESET, ir_out=0, ir_valid=0, imem_req=0, timeout_err=0, timeout counter=0.
REQ-029 Reset asserted mid-FETCH or mid-HOLD shall abandon the transaction; a later imem_ack shall be ignored until the FSM re-enters FETCH.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: a counter shall clear on FETCH entry and increment each FETCH cycle without imem_ack.
REQ-031 With FETCH_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC: timeout_err<=1 (sticky until reset), imem_req drops, and the FSM -> IDLE.
REQ-032 Macro FETCH_TIMEOUT_EN undefined: no counter shall be built, timeout_err shall be tied 0, and FETCH shall wait indefinitely.

Structure
REQ-033 Shared package fetch_pkg shall hold the state encoding (IDLE=2'b00, FETCH=2'b01, HOLD=2'b10) and the PC_RESET and TIMEOUT_CYC defaults.
REQ-034 One sub-module, fetch_timer (counter plus compare), shall be instantiated only under FETCH_TIMEOUT_EN.
REQ-035 The PC select mux shall stay external; fetch_ctl only drives pc_inc and consumes next_pc.

Verification
REQ-036 Reset, start=1, ack after 2 cycles with data 32'hDEAD_BEEF -> imem_addr=0, ir_out=32'hDEAD_BEEF, ir_valid=1.
REQ-037 HOLD, ir_ready=1, stall=1 for 3 cycles, then stall=0, next_pc=32'h0000_0010 -> pc_out holds 0 during the stall, then becomes 32'h10, and imem_req rises next cycle.
REQ-038 pc_out=32'hFFFF_FFFF -> pc_inc=32'h0000_0000; feed it back as next_pc -> next fetch at address 0.
REQ-039 imem_ack and stall=1 simultaneously in FETCH -> instruction captured and state=HOLD.
REQ-040 rst_f low during FETCH, then a late ack -> ir_valid stays 0 and pc_out=PC_RESET.
REQ-041 FETCH_TIMEOUT_EN defined with no ack for 255 cycles -> timeout_err=1, imem_req=0, state=IDLE; macro undefined -> imem_req still 1 after 300 cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared FSM state encoding and default parameters for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [31:0] PC_RESET_DEF    = 32'h0000_0000;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/fetch_timer.sv
// Fetch watchdog: counts FETCH cycles without ack, flags the cycle the limit is reached.
// Zero-latency compare on the registered count; clr has priority over tick.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic tick,
  output logic hit
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the tick that takes the count to TIMEOUT_CYC.
  assign hit = tick && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_ctl.sv
// Instruction fetch controller: IDLE/FETCH/HOLD sequencing, PC and instruction register.
// One cycle from handshake to next request; HOLD stalls on !ir_ready or stall. Option: FETCH_TIMEOUT_EN.
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = PC_RESET_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        start,
  input  logic        stall,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_out,
  output logic [31:0] pc_inc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        timeout_err
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        hs;
  logic        tmo_hit;

  assign hs = (state == HOLD) && ir_ready && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      // Ack wins over stall and over a coincident timeout.
      FETCH: begin
        if (imem_ack)     state_nxt = HOLD;
        else if (tmo_hit) state_nxt = IDLE;
      end
      HOLD:    if (hs) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= IDLE;
      pc_q  <= PC_RESET;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) ir_q <= imem_data;
      if (hs)                         pc_q <= next_pc;
    end
  end

  assign pc_out    = pc_q;
  assign pc_inc    = pc_q + 32'd1;
  assign imem_addr = pc_q;
  assign imem_req  = (state == FETCH);
  assign ir_out    = ir_q;
  assign ir_valid  = (state == HOLD);

`ifdef FETCH_TIMEOUT_EN
  logic tmo_err_q;

  fetch_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_f (rst_f),
    .clr   ((state != FETCH) && (state_nxt == FETCH)),
    .tick  ((state == FETCH) && !imem_ack),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      tmo_err_q <= 1'b0;
    end else if (tmo_hit) begin
      tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed and scoreboarded checks of fetch_ctl sequencing, PC update, reset and timeout.
module tb_fetch_ctl;
  logic        clk = 1'b0;
  logic        rst_f;
  logic        start;
  logic        stall;
  logic [31:0] next_pc;
  logic [31:0] pc_out;
  logic [31:0] pc_inc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ir_q[$];

  fetch_ctl dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .start       (start),
    .stall       (stall),
    .next_pc     (next_pc),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_addr(output logic [31:0] a);
    if (exp_addr_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL addr_queue_empty: observed 0 entries expected >=1");
      a = 32'hx;
    end else begin
      a = exp_addr_q.pop_front();
    end
  endtask

  // In FETCH: check the request, ack after dly cycles, then wait for ir_valid and compare.
  task automatic do_fetch(input string tag, input logic [31:0] data, input int dly, input logic stl);
    logic [31:0] ea;
    int          n;
    pop_addr(ea);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, ea);
    repeat (dly) step();
    imem_ack  = 1'b1;
    imem_data = data;
    stall     = stl;
    exp_ir_q.push_back(data);
    step();
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    stall     = 1'b0;
    n = 0;
    while (!ir_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd1);
    chk({tag, "_ir_out"}, ir_out, exp_ir_q.pop_front());
    chk({tag, "_req_low"}, {31'd0, imem_req}, 32'd0);
  endtask

  // In HOLD: delay ready, then hand off; next_pc may be driven from pc_inc.
  task automatic handshake(input string tag, input logic [31:0] npc, input int rdly, input bit use_inc);
    logic [31:0] pc0;
    pc0 = pc_out;
    ir_ready = 1'b0;
    repeat (rdly) step();
    if (rdly > 0) chk({tag, "_pc_hold"}, pc_out, pc0);
    ir_ready = 1'b1;
    next_pc  = use_inc ? pc_inc : npc;
    exp_addr_q.push_back(npc);
    step();
    ir_ready = 1'b0;
    chk({tag, "_pc_new"}, pc_out, npc);
    chk({tag, "_valid_clr"}, {31'd0, ir_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ea;
    int          n;
    rst_f = 1'b0; start = 1'b0; stall = 1'b0; next_pc = '0;
    imem_ack = 1'b0; imem_data = '0; ir_ready = 1'b0;
    step(); step();

    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc_inc", pc_inc, 32'h1);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ir", ir_out, 32'h0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);

    rst_f = 1'b1;
    step();
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    exp_addr_q.push_back(32'h0);
    step();
    start = 1'b0;
    do_fetch("deadbeef", 32'hDEAD_BEEF, 2, 1'b0);

    // Start while in HOLD must have no effect.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_valid", {31'd0, ir_valid}, 32'd1);
    chk("start_ignored_req", {31'd0, imem_req}, 32'd0);

    // Ready but stalled for 3 cycles: nothing moves.
    ir_ready = 1'b1; stall = 1'b1; next_pc = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_out, 32'h0);
      chk("stall_ir", ir_out, 32'hDEAD_BEEF);
      chk("stall_valid", {31'd0, ir_valid}, 32'd1);
    end
    stall = 1'b0;
    exp_addr_q.push_back(32'h10);
    step();
    ir_ready = 1'b0;
    chk("unstall_pc", pc_out, 32'h10);
    chk("unstall_valid", {31'd0, ir_valid}, 32'd0);

    // Ack together with stall still captures.
    do_fetch("ack_stall", 32'h1234_5678, 0, 1'b1);

    handshake("to_max", 32'hFFFF_FFFF, 2, 1'b0);
    chk("wrap_pc_inc", pc_inc, 32'h0);
    do_fetch("at_max", 32'hA5A5_5A5A, 1, 1'b0);
    handshake("wrap", 32'h0, 0, 1'b1);
    pop_addr(ea);
    chk("wrap_addr", imem_addr, ea);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);

    // Asynchronous reset mid-FETCH, then a stale ack.
    @(posedge clk);
    #2 rst_f = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc_out, 32'h0);
    step();
    rst_f = 1'b1;
    imem_ack = 1'b1; imem_data = 32'hBAD0_BAD0;
    step(); step();
    imem_ack = 1'b0; imem_data = '0;
    chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    chk("late_ack_ir", ir_out, 32'h0);
    chk("late_ack_pc", pc_out, 32'h0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd0);

    // Scoreboarded stream with random data, ack delay and ready delay.
    start = 1'b1;
    exp_addr_q.push_back(32'h0);
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_fetch("rnd", $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      handshake("rnd", $urandom, $urandom_range(0, 3), 1'b0);
    end
    pop_addr(ea);
    chk("rnd_last_addr", imem_addr, ea);

    // Timeout behaviour from a clean start.
    rst_f = 1'b0;
    step();
    rst_f = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (imem_req && n < 400) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 32'd255);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_req", {31'd0, imem_req}, 32'd0);
    chk("tmo_valid", {31'd0, ir_valid}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_restart_req", {31'd0, imem_req}, 32'd1);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
`else
    n = 0;
    repeat (300) begin
      step();
      n++;
    end
    chk("notmo_req", {31'd0, imem_req}, 32'd1);
    chk("notmo_err", {31'd0, timeout_err}, 32'd0);
    chk("notmo_addr", imem_addr, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected completion within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
